global_stream_mux: RTL

//  N-channel, parametrised-width stream multiplexer with a registered output stage and

---
 rtl/global_stream_mux.sv | 106 ++++++++++
 1 files changed

// File: rtl/global_stream_mux.sv
// N-channel stream multiplexer with a registered output stage.
// The channel is chosen by an explicit select (mode 0) or by round-robin arbitration (mode 1).
module global_stream_mux #(
    parameter int unsigned BITS     = 31,
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned SELW     = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         mode,
    input  logic [SELW-1:0]              sel,
    input  logic [CHANNELS-1:0]          in_valid,
    input  logic [(BITS+1)*CHANNELS-1:0] in_data,
    output logic [CHANNELS-1:0]          in_ready,
    output logic                         out_valid,
    output logic [BITS:0]                out_data,
    output logic [SELW-1:0]              out_src,
    input  logic                         out_ready,
    output logic                         sel_err
);

    localparam int unsigned DW = BITS + 1;

    logic                r_out_valid;
    logic [DW-1:0]       r_out_data;
    logic [SELW-1:0]     r_out_src;
    logic                r_sel_err;
    logic [SELW-1:0]     r_last;

    logic                w_load_en;
    logic                w_sel_oob;
    logic                w_grant_vld;
    logic [SELW-1:0]     w_grant;
    logic [CHANNELS-1:0] w_ready;
    logic                w_xfer;
    logic [DW-1:0]       w_data;
    logic [CHANNELS-1:0] w_valid_rot;
    int unsigned         w_idx;

    // The output register can accept a word when empty or draining this cycle
    assign w_load_en = !r_out_valid || out_ready;
    assign w_sel_oob = (32'(sel) >= CHANNELS);

    // Grant selection: explicit select, or first valid channel after the last winner
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        w_idx       = 0;
        w_valid_rot = '0;
        if (!mode) begin
            if (!w_sel_oob) begin
                w_grant_vld = 1'b1;
                w_grant     = sel;
            end
        end else begin
            for (int unsigned i = 1; i <= CHANNELS; i++) begin
                w_idx       = (32'(r_last) + i) % CHANNELS;
                w_valid_rot = in_valid >> w_idx;
                if (!w_grant_vld && w_valid_rot[0]) begin
                    w_grant_vld = 1'b1;
                    w_grant     = SELW'(w_idx);
                end
            end
        end
    end

    // One-hot ready to the granted channel, data mux and transfer detect
    always_comb begin
        w_ready = '0;
        if (w_grant_vld) begin
            w_ready = CHANNELS'(w_load_en) << w_grant;
        end
        w_xfer = |(w_ready & in_valid);
        w_data = DW'(in_data >> (32'(w_grant) * DW));
    end

    // Output register, round-robin pointer and select-error flag
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_src   <= '0;
            r_sel_err   <= 1'b0;
            r_last      <= SELW'(CHANNELS - 1);
        end else begin
            r_sel_err <= !mode && w_sel_oob;
            if (w_load_en) begin
                r_out_valid <= w_xfer;
                if (w_xfer) begin
                    r_out_data <= w_data;
                    r_out_src  <= w_grant;
                    if (mode) begin
                        r_last <= w_grant;
                    end
                end
            end
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_src   = r_out_src;
    assign sel_err   = r_sel_err;

endmodule
